// File: rtl/cache_pmem_arbiter_pkg.sv
// ============================================================================
// Module : rv32i_types (package)
// Brief  : Shared types for the I/D-cache physical-memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_req_t;

    localparam int unsigned LINE_WIDTH_DEF = 256;
    localparam int unsigned ADDR_WIDTH_DEF = 32;

endpackage

`default_nettype wire

// File: rtl/cache_pmem_arbiter_if.sv
// ============================================================================
// Module : cache_pmem_arbiter_if
// Brief  : Bundle of I-cache, D-cache and pmem line-port signals.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cache_pmem_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  icache_pmem_read;
    logic [ADDR_WIDTH-1:0] icache_pmem_address;
    logic [LINE_WIDTH-1:0] icache_pmem_rdata;
    logic                  icache_pmem_resp;

    logic                  dcache_pmem_read;
    logic                  dcache_pmem_write;
    logic [ADDR_WIDTH-1:0] dcache_pmem_address;
    logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
    logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
    logic                  dcache_pmem_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    logic                  arb_busy;

    // Arbiter side
    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output arb_busy
    );

    // Caches plus adaptor side
    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  arb_busy
    );

endinterface

`default_nettype wire

// File: rtl/cache_pmem_arbiter_priority_select.sv
// ============================================================================
// Module : arb_priority_select
// Brief  : Combinational winner pick between I and D requests.
//          ARB_RR_EN: a tie goes to the requester not granted last.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_priority_select
    import rv32i_types::*;
(
    input  wire logic     icache_req_i,
    input  wire logic     dcache_req_i,
    input  wire arb_req_t last_grant_i,
    output logic          any_req_o,
    output arb_req_t      winner_o
);

    always_comb begin
        any_req_o = icache_req_i | dcache_req_i;
        winner_o  = ARB_D;
        if (icache_req_i && !dcache_req_i) begin
            winner_o = ARB_I;
        end
`ifdef ARB_RR_EN
        else if (icache_req_i && dcache_req_i && (last_grant_i == ARB_D)) begin
            winner_o = ARB_I;
        end
`endif
    end

`ifndef ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

`default_nettype wire

// File: rtl/cache_pmem_arbiter.sv
// ============================================================================
// Module : cache_pmem_arbiter
// Brief  : Shares the pmem line port between I-cache and D-cache misses.
//          Optional macro ARB_RR_EN enables round-robin tie breaking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_pmem_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    cache_pmem_arbiter_if.slave   bus
);

    arb_state_t state_q;
    arb_req_t   winner;
    arb_req_t   last_grant;
    logic       any_req;
    logic       dcache_req;

    assign dcache_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

    arb_priority_select u_select (
        .icache_req_i (bus.icache_pmem_read),
        .dcache_req_i (dcache_req),
        .last_grant_i (last_grant),
        .any_req_o    (any_req),
        .winner_o     (winner)
    );

`ifdef ARB_RR_EN
    arb_req_t last_grant_q;
    assign last_grant = last_grant_q;
`else
    assign last_grant = ARB_I;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
`ifdef ARB_RR_EN
            last_grant_q <= ARB_I;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= (winner == ARB_D) ? SERVE_D : SERVE_I;
`ifdef ARB_RR_EN
                        last_grant_q <= winner;
`endif
                    end
                end
                // Grant is held until the adaptor completes, even if the request drops
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state_q <= RELEASE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // State-derived outputs, so an asynchronous reset clears them immediately
    always_comb begin
        bus.pmem_read         = 1'b0;
        bus.pmem_write        = 1'b0;
        bus.pmem_address      = {ADDR_WIDTH{1'b0}};
        bus.pmem_wdata        = {LINE_WIDTH{1'b0}};
        bus.icache_pmem_resp  = 1'b0;
        bus.icache_pmem_rdata = {LINE_WIDTH{1'b0}};
        bus.dcache_pmem_resp  = 1'b0;
        bus.dcache_pmem_rdata = {LINE_WIDTH{1'b0}};
        case (state_q)
            SERVE_I: begin
                bus.pmem_read        = bus.icache_pmem_read;
                bus.pmem_address     = bus.icache_pmem_address;
                bus.icache_pmem_resp = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    bus.icache_pmem_rdata = bus.pmem_rdata;
                end
            end
            SERVE_D: begin
                // Read+write together is illegal; the write takes precedence
                bus.pmem_write       = bus.dcache_pmem_write;
                bus.pmem_read        = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
                bus.pmem_address     = bus.dcache_pmem_address;
                bus.pmem_wdata       = bus.dcache_pmem_wdata;
                bus.dcache_pmem_resp = bus.pmem_resp;
                if (bus.pmem_resp) begin
                    bus.dcache_pmem_rdata = bus.pmem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.arb_busy = (state_q != IDLE);

`ifndef SYNTHESIS
    a_dcache_rw_exclusive: assert property (
        @(posedge clk) disable iff (!reset)
        !(bus.dcache_pmem_read && bus.dcache_pmem_write)
    ) else $error("dcache read and write asserted together");
`endif

endmodule

`default_nettype wire
